mem_port_arbiter: RTL

Shares one single-ported instruction/data memory between the fetch stage (read-only) and the memory-access stage (read/write) of the five-stage pipeline. It serialises requests onto a req/ready memory port and gives each stage a stall signal and a one-cycle completion pulse. Data accesses take priority, because they belong to the older instruction. A run limiter guarantees that fetch is granted at least once per MAX_DATA_RUN consecutive data grants.

---
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch (read) and data (read/write).
// Ports: if_* fetch side, d_* data side, m_* memory port, owner = granted side.
module mem_port_arbiter #(
  parameter int unsigned MAX_DATA_RUN = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        d_stall,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_be,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic        owner
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DATA
  } state_t;

  localparam logic [3:0] RUN_MAX = 4'(MAX_DATA_RUN);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] run_cnt;
  logic       if_elig;
  logic       d_elig;
  logic       grant_d;
  logic       grant_f;
  logic       done;

  // valid=1 masks the request that just completed
  assign if_elig = if_req & ~if_valid;
  assign d_elig  = d_req & ~d_valid;

  assign grant_d = (state == IDLE) & d_elig &
                   (~if_elig | (run_cnt < RUN_MAX));
  assign grant_f = (state == IDLE) & ~grant_d & if_elig;
  assign done    = (state != IDLE) & m_ready;

  assign if_stall = if_req & ~if_valid;
  assign d_stall  = d_req & ~d_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      grant_d: state_nxt = DATA;
      grant_f: state_nxt = FETCH;
      done:    state_nxt = IDLE;
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt  <= '0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_be     <= '0;
      owner    <= 1'b0;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      if (grant_d) begin
        m_req   <= 1'b1;
        m_we    <= d_we;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
        m_be    <= d_be;
        owner   <= 1'b1;
        if (!if_elig)
          run_cnt <= '0;
        else if (run_cnt != RUN_MAX)
          run_cnt <= run_cnt + 4'd1;
      end else if (grant_f) begin
        m_req   <= 1'b1;
        m_we    <= 1'b0;
        m_addr  <= if_addr;
        m_be    <= 4'hF;
        owner   <= 1'b0;
        run_cnt <= '0;
      end else if (done) begin
        m_req <= 1'b0;
        if (state == FETCH) begin
          if_valid <= 1'b1;
          if_rdata <= m_rdata;
        end else begin
          d_valid <= 1'b1;
          if (!m_we) d_rdata <= m_rdata;
        end
      end
    end
  end

endmodule
